audio_frame_sched: RTL and testbench

Frame scheduler for the audio engine. It counts I2S frame ticks, keeps the input-RAM write frame pointer, and arbitrates the audio input RAM write port between the I2S receiver and the host. It also sequences the sequencer once per frame: it holds the sequencer off, then releases it on the latched frame index and waits for done. Overruns are recorded for the status register. It sits between the I2S Rx, the bus peripheral's control/status logic and the sequencer.

---
 rtl/audio_pkg.sv | 21 ++
 rtl/audio_frame_sched_if.sv | 16 +
 rtl/audio_wr_arb.sv | 50 +++++
 rtl/audio_frame_sched.sv | 133 +++++++++++++
 tb/tb_audio_frame_sched.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/audio_pkg.sv
// Shared definitions for the audio frame scheduler.
//   CHANNELS / FRAMES size the audio input RAM (channel x frame).
//   CHAN_W, FRAME_W, AUDIO_W are the derived index and address widths.
//   CNT_W is the width of the saturating overrun counter.
//   sched_state_t is the per-frame sequencer FSM state.
package audio_pkg;

  localparam int CHANNELS = 16;
  localparam int FRAMES   = 32;
  localparam int CHAN_W   = $clog2(CHANNELS);
  localparam int FRAME_W  = $clog2(FRAMES);
  localparam int AUDIO_W  = CHAN_W + FRAME_W;
  localparam int CNT_W    = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GAP  = 2'd1,
    RUN  = 2'd2
  } sched_state_t;

endpackage

// File: rtl/audio_frame_sched_if.sv
// Audio input RAM write port.
//   we     write enable
//   waddr  word address {frame, channel}
//   wdata  16-bit sample
// master: the scheduler driving the port; slave: the RAM.
interface audio_frame_sched_if;
  import audio_pkg::*;

  logic               we;
  logic [AUDIO_W-1:0] waddr;
  logic [15:0]        wdata;

  modport master (output we, waddr, wdata);
  modport slave  (input  we, waddr, wdata);

endinterface

// File: rtl/audio_wr_arb.sv
// Registered two-source write mux for the audio input RAM.
//   ck, rst            clock, asynchronous active-high reset
//   host_sel           1: host owns the port, 0: I2S Rx owns it
//   host_we/addr/data  host write request
//   rx_we/chan/data    Rx sample write request
//   wr_frame           frame being filled by Rx (forms the upper address)
//   ram                registered write port, one cycle after the strobe
module audio_wr_arb
  import audio_pkg::*;
(
  input  logic               ck,
  input  logic               rst,
  input  logic               host_sel,
  input  logic               host_we,
  input  logic [AUDIO_W-1:0] host_addr,
  input  logic [15:0]        host_data,
  input  logic               rx_we,
  input  logic [CHAN_W-1:0]  rx_chan,
  input  logic [15:0]        rx_data,
  input  logic [FRAME_W-1:0] wr_frame,
  audio_frame_sched_if.master ram
);

  // The non-owner's strobe is simply ignored; nothing is queued, so a write
  // is never delayed or merged with a later one.
  always_ff @(posedge ck or posedge rst) begin
    // NOTE: address/data are reset too, because every output must read 0
    // while reset is asserted, not only the enable.
    if (rst) begin
      ram.we    <= 1'b0;
      ram.waddr <= '0;
      ram.wdata <= '0;
    end else if (host_sel) begin
      ram.we <= host_we;
      if (host_we) begin
        ram.waddr <= host_addr;
        ram.wdata <= host_data;
      end
    end else begin
      ram.we <= rx_we;
      if (rx_we) begin
        // wr_frame is the pre-increment value even when a frame tick is
        // sampled on the same edge.
        ram.waddr <= {wr_frame, rx_chan};
        ram.wdata <= rx_data;
      end
    end
  end

endmodule

// File: rtl/audio_frame_sched.sv
// Frame scheduler for the audio engine.
//   ck, rst        clock, asynchronous active-high reset
//   frame_tick     one-cycle pulse at the end of each I2S frame
//   rx_*           I2S Rx sample write request
//   host_*         host write request and port ownership bit
//   seq_done       sequencer done level
//   ovr_clr        clears the overrun flag and counter
//   ram            registered input-RAM write port
//   seq_run        sequencer enable (low holds it in reset)
//   seq_frame      frame index latched for the current run
//   wr_frame       frame currently being filled by Rx
//   busy           a run is in progress
//   overrun        sticky: a tick arrived while a run was in progress
//   ovr_count      saturating count of such ticks
module audio_frame_sched
  import audio_pkg::*;
(
  input  logic               ck,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               rx_we,
  input  logic [CHAN_W-1:0]  rx_chan,
  input  logic [15:0]        rx_data,
  input  logic               host_sel,
  input  logic               host_we,
  input  logic [AUDIO_W-1:0] host_addr,
  input  logic [15:0]        host_data,
  input  logic               seq_done,
  input  logic               ovr_clr,
  audio_frame_sched_if.master ram,
  output logic               seq_run,
  output logic [FRAME_W-1:0] seq_frame,
  output logic [FRAME_W-1:0] wr_frame,
  output logic               busy,
  output logic               overrun,
  output logic [CNT_W-1:0]   ovr_count
);

  sched_state_t state, state_nxt;
  logic         gap_cnt;    // 0 in the first GAP cycle, 1 in the second
  logic         run_first;  // high during the first RUN cycle only
  logic         ran;        // a run has reached RUN since reset
  logic         start_run;
  logic         ovr_tick;

  assign start_run = frame_tick && (state == IDLE);
  assign ovr_tick  = frame_tick && (state != IDLE);

  // State register.
  always_ff @(posedge ck or posedge rst) begin
    // NOTE: sequential state always uses non-blocking assignments so every
    // register samples pre-edge values regardless of block ordering.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default first so no path leaves state_nxt unassigned (no latch).
    state_nxt = state;
    unique case (state)
      IDLE:    if (frame_tick) state_nxt = GAP;
      GAP:     if (gap_cnt) state_nxt = RUN;
      // Done is stale in the first RUN cycle: the sequencer has only just
      // come out of reset.
      RUN:     if (seq_done && !run_first) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic. In IDLE seq_run holds its last value: low after reset,
  // high after a completed run so results and done remain readable.
  always_comb begin
    busy    = (state != IDLE);
    seq_run = 1'b0;
    unique case (state)
      IDLE:    seq_run = ran;
      GAP:     seq_run = 1'b0;
      RUN:     seq_run = 1'b1;
      default: seq_run = 1'b0;
    endcase
  end

  // Gap timing, run bookkeeping and frame pointers.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      gap_cnt   <= 1'b0;
      run_first <= 1'b0;
      ran       <= 1'b0;
      wr_frame  <= '0;
      seq_frame <= '0;
    end else begin
      if (start_run)          gap_cnt <= 1'b0;
      else if (state == GAP)  gap_cnt <= 1'b1;
      run_first <= (state == GAP) && gap_cnt;
      if (state == RUN) ran <= 1'b1;
      // wr_frame advances on every tick, overrun or not; it wraps naturally.
      if (frame_tick) wr_frame <= wr_frame + 1'b1;
      if (start_run)  seq_frame <= wr_frame;
    end
  end

  // Overrun flag and saturating counter. A tick coinciding with a clear
  // wins and counts as the first overrun after the clear.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      overrun   <= 1'b0;
      ovr_count <= '0;
    end else if (ovr_tick) begin
      overrun <= 1'b1;
      if (ovr_clr)              ovr_count <= CNT_W'(1);
      else if (ovr_count != '1) ovr_count <= ovr_count + 1'b1;
    end else if (ovr_clr) begin
      overrun   <= 1'b0;
      ovr_count <= '0;
    end
  end

  audio_wr_arb u_wr_arb (
    .ck        (ck),
    .rst       (rst),
    .host_sel  (host_sel),
    .host_we   (host_we),
    .host_addr (host_addr),
    .host_data (host_data),
    .rx_we     (rx_we),
    .rx_chan   (rx_chan),
    .rx_data   (rx_data),
    .wr_frame  (wr_frame),
    .ram       (ram)
  );

endmodule

// File: tb/tb_audio_frame_sched.sv
// Self-checking bench for audio_frame_sched: randomized stimulus, a
// behavioural frame/run/overrun model, and a monitor that scores RAM writes,
// run starts and the status outputs every cycle.
module tb_audio_frame_sched;
  import audio_pkg::*;

  logic               ck;
  logic               rst;
  logic               frame_tick, rx_we, host_sel, host_we, seq_done, ovr_clr;
  logic [CHAN_W-1:0]  rx_chan;
  logic [15:0]        rx_data, host_data;
  logic [AUDIO_W-1:0] host_addr;
  logic               seq_run, busy, overrun;
  logic [FRAME_W-1:0] seq_frame, wr_frame;
  logic [CNT_W-1:0]   ovr_count;

  audio_frame_sched_if ram_if ();

  audio_frame_sched dut (
    .ck (ck), .rst (rst), .frame_tick (frame_tick),
    .rx_we (rx_we), .rx_chan (rx_chan), .rx_data (rx_data),
    .host_sel (host_sel), .host_we (host_we), .host_addr (host_addr), .host_data (host_data),
    .seq_done (seq_done), .ovr_clr (ovr_clr), .ram (ram_if),
    .seq_run (seq_run), .seq_frame (seq_frame), .wr_frame (wr_frame),
    .busy (busy), .overrun (overrun), .ovr_count (ovr_count)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  typedef struct {
    logic [AUDIO_W-1:0] addr;
    logic [15:0]        data;
    int                 due;
  } wr_t;

  wr_t exp_wr[$];
  int  exp_run[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Behavioural model: m_age counts edges since the starting tick.
  int m_wr = 0, m_seq = 0, m_cnt = 0, m_age = 0;
  bit m_idle = 1'b1, m_ovr = 1'b0, m_ran = 1'b0;

  always @(posedge ck) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_wr = 0; m_seq = 0; m_cnt = 0; m_age = 0;
    m_idle = 1'b1; m_ovr = 1'b0; m_ran = 1'b0;
    exp_wr.delete();
    exp_run.delete();
  endtask

  // Random write traffic for the coming edge; the expected RAM write follows
  // the ownership rule with the frame pointer as it stands before the edge.
  task automatic rand_wr();
    host_sel  = 1'($urandom_range(0, 1));
    rx_we     = 1'($urandom_range(0, 1));
    host_we   = 1'($urandom_range(0, 1));
    rx_chan   = CHAN_W'($urandom);
    rx_data   = 16'($urandom);
    host_addr = AUDIO_W'($urandom);
    host_data = 16'($urandom);
    if (host_sel && host_we)
      exp_wr.push_back('{host_addr, host_data, cyc + 1});
    else if (!host_sel && rx_we)
      exp_wr.push_back('{AUDIO_W'(m_wr * CHANNELS + int'(rx_chan)), rx_data, cyc + 1});
  endtask

  // One clock edge. wr_mode: 0 no writes, 1 random writes, 2 caller-set writes.
  task automatic clk_step(input int wr_mode);
    bit tick_v, clr_v, done_v, was_idle;
    if (wr_mode == 1) rand_wr();
    else if (wr_mode == 0) begin rx_we = 1'b0; host_we = 1'b0; end
    tick_v = frame_tick;
    clr_v  = ovr_clr;
    done_v = seq_done;
    @(posedge ck);
    #1;
    was_idle = m_idle;
    if (!m_idle) begin
      if (done_v && m_age >= 3) m_idle = 1'b1;
      else begin
        m_age++;
        if (m_age >= 2) m_ran = 1'b1;
      end
    end
    if (tick_v) begin
      if (was_idle) begin
        m_seq  = m_wr;
        exp_run.push_back(m_wr);
        m_idle = 1'b0;
        m_age  = 0;
      end else begin
        m_ovr = 1'b1;
        m_cnt = clr_v ? 1 : ((m_cnt == 255) ? 255 : m_cnt + 1);
      end
      m_wr = (m_wr + 1) % FRAMES;
    end else if (clr_v) begin
      m_ovr = 1'b0;
      m_cnt = 0;
    end
    frame_tick = 1'b0;
    ovr_clr    = 1'b0;
  endtask

  task automatic stir();
    frame_tick = ($urandom_range(0, 7) == 0);
    ovr_clr    = ($urandom_range(0, 7) == 0);
  endtask

  task automatic run_frame(input bit rx_on_tick, input bit noise);
    int d;
    d = $urandom_range(0, 4);
    seq_done   = 1'($urandom_range(0, 1));  // stale done must not matter
    frame_tick = 1'b1;
    if (rx_on_tick) begin
      host_sel = 1'b0; rx_we = 1'b1; host_we = 1'b0;
      rx_chan  = CHAN_W'(10); rx_data = 16'h5A5A;
      exp_wr.push_back('{AUDIO_W'(m_wr * CHANNELS + 10), 16'h5A5A, cyc + 1});
      clk_step(2);
    end else clk_step(1);
    for (int k = 0; k < 2; k++) begin
      if (noise) stir();
      clk_step(1);
    end
    for (int k = 0; k < 64 && !m_idle; k++) begin
      seq_done = (k >= d);
      if (noise) stir();
      clk_step(1);
    end
    seq_done = 1'($urandom_range(0, 1));
    repeat ($urandom_range(0, 3)) clk_step(1);
  endtask

  task automatic do_reset();
    rx_we = 1'b0; host_we = 1'b0; frame_tick = 1'b0; ovr_clr = 1'b0; seq_done = 1'b0;
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_seq_run",   32'(seq_run),   32'(0));
    check("rst_busy",      32'(busy),      32'(0));
    check("rst_wr_frame",  32'(wr_frame),  32'(0));
    check("rst_seq_frame", 32'(seq_frame), 32'(0));
    check("rst_ram_we",    32'(ram_if.we), 32'(0));
    check("rst_overrun",   32'(overrun),   32'(0));
    check("rst_ovr_count", 32'(ovr_count), 32'(0));
    @(posedge ck); #1;
    @(posedge ck); #1;
    rst = 1'b0;
  endtask

  // Monitor: scores writes and run starts against the queues and the
  // status outputs against the model.
  bit  prev_run = 1'b0;
  wr_t e;
  int  er;
  always @(negedge ck) begin
    if (!rst) begin
      while (exp_wr.size() > 0 && exp_wr[0].due < cyc) begin
        e = exp_wr.pop_front();
        n_vec++; n_err++;
        $display("FAIL missing_write: got none, want addr=%0h data=%0h", e.addr, e.data);
      end
      if (ram_if.we === 1'b1) begin
        if (exp_wr.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_write: got addr=%0h data=%0h, want none", ram_if.waddr, ram_if.wdata);
        end else begin
          e = exp_wr.pop_front();
          check("wr_due",  32'(cyc),          32'(e.due));
          check("wr_addr", 32'(ram_if.waddr), 32'(e.addr));
          check("wr_data", 32'(ram_if.wdata), 32'(e.data));
        end
      end else check("wr_idle", 32'(ram_if.we), 32'(0));
      if (seq_run === 1'b1 && !prev_run) begin
        if (exp_run.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_run: got seq_frame=%0d, want no run", seq_frame);
        end else begin
          er = exp_run.pop_front();
          check("run_seq_frame", 32'(seq_frame), 32'(er));
        end
      end
      check("busy",      32'(busy),      32'(!m_idle));
      check("seq_run",   32'(seq_run),   32'(m_idle ? m_ran : (m_age >= 2)));
      check("wr_frame",  32'(wr_frame),  32'(m_wr));
      check("seq_frame", 32'(seq_frame), 32'(m_seq));
      check("overrun",   32'(overrun),   32'(m_ovr));
      check("ovr_count", 32'(ovr_count), 32'(m_cnt));
    end
    prev_run = (seq_run === 1'b1);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, want finish before 1 ms");
    $fatal(1, "watchdog");
  end

  initial begin
    int  sf;
    bit  wrap_seen;
    rst = 1'b0; frame_tick = 1'b0; rx_we = 1'b0; host_sel = 1'b0; host_we = 1'b0;
    seq_done = 1'b0; ovr_clr = 1'b0; rx_chan = '0; rx_data = '0;
    host_addr = '0; host_data = '0;
    wrap_seen = 1'b0;
    #2;
    do_reset();

    // Single run with explicit timing.
    frame_tick = 1'b1;
    clk_step(0);
    check("run1_wr_frame",  32'(wr_frame),  32'(1));
    check("run1_seq_frame", 32'(seq_frame), 32'(0));
    check("run1_busy",      32'(busy),      32'(1));
    check("run1_gap0",      32'(seq_run),   32'(0));
    clk_step(0);
    check("run1_gap1",      32'(seq_run),   32'(0));
    clk_step(0);
    check("run1_run",       32'(seq_run),   32'(1));
    seq_done = 1'b1;  // sampled in the first RUN cycle: ignored
    clk_step(0);
    check("run1_stale_done", 32'(busy),     32'(1));
    clk_step(0);
    check("run1_done_busy", 32'(busy),      32'(0));
    check("run1_hold_run",  32'(seq_run),   32'(1));
    seq_done = 1'b0;

    // Frames 1..4, one with an Rx write on the tick edge.
    run_frame(1'b1, 1'b0);
    repeat (3) run_frame(1'b0, 1'b0);
    check("pre_rx_frame", 32'(wr_frame), 32'(5));

    // Rx owns the port; the host write is dropped.
    host_sel = 1'b0; rx_we = 1'b1; rx_chan = CHAN_W'(3); rx_data = 16'hBEEF;
    host_we = 1'b1; host_addr = AUDIO_W'(9'h0AA); host_data = 16'h1234;
    exp_wr.push_back('{AUDIO_W'(9'h053), 16'hBEEF, cyc + 1});
    clk_step(2);
    check("rx_we",   32'(ram_if.we),    32'(1));
    check("rx_addr", 32'(ram_if.waddr), 32'(9'h053));
    check("rx_data", 32'(ram_if.wdata), 32'(16'hBEEF));

    // Host owns the port; the Rx write is dropped.
    host_sel = 1'b1; host_we = 1'b1; host_addr = AUDIO_W'(9'h1FF); host_data = 16'hCAFE;
    rx_we = 1'b1; rx_chan = CHAN_W'(7); rx_data = 16'h0BAD;
    exp_wr.push_back('{AUDIO_W'(9'h1FF), 16'hCAFE, cyc + 1});
    clk_step(2);
    check("host_we",   32'(ram_if.we),    32'(1));
    check("host_addr", 32'(ram_if.waddr), 32'(9'h1FF));
    check("host_data", 32'(ram_if.wdata), 32'(16'hCAFE));
    host_sel = 1'b0; rx_we = 1'b0; host_we = 1'b1;
    clk_step(2);
    check("drop_host", 32'(ram_if.we), 32'(0));
    host_sel = 1'b1; host_we = 1'b0; rx_we = 1'b1;
    clk_step(2);
    check("drop_rx", 32'(ram_if.we), 32'(0));

    // Wrap: 32 more runs passes through seq_frame = 31.
    for (int i = 0; i < 32; i++) begin
      run_frame(1'b0, 1'b0);
      if (m_seq == 31) begin
        wrap_seen = 1'b1;
        check("wrap_seq_frame", 32'(seq_frame), 32'(31));
        check("wrap_wr_frame",  32'(wr_frame),  32'(0));
      end
    end
    check("wrap_seen", 32'(wrap_seen), 32'(1));

    // Overrun: 300 ticks while a run is in progress.
    sf = m_wr;
    seq_done = 1'b0; frame_tick = 1'b1;
    clk_step(1);
    for (int i = 0; i < 300; i++) begin
      frame_tick = 1'b1;
      clk_step(1);
    end
    check("ovr_flag_sat",  32'(overrun),   32'(1));
    check("ovr_count_sat", 32'(ovr_count), 32'(255));
    check("ovr_seq_frame", 32'(seq_frame), 32'(sf));
    check("ovr_busy",      32'(busy),      32'(1));
    ovr_clr = 1'b1; frame_tick = 1'b1;
    clk_step(1);
    check("clr_tick_flag",  32'(overrun),   32'(1));
    check("clr_tick_count", 32'(ovr_count), 32'(1));
    ovr_clr = 1'b1;
    clk_step(1);
    check("clr_flag",  32'(overrun),   32'(0));
    check("clr_count", 32'(ovr_count), 32'(0));
    for (int k = 0; k < 64 && !m_idle; k++) begin
      seq_done = 1'b1;
      clk_step(1);
    end
    seq_done = 1'b0;

    // Reset in the middle of RUN.
    frame_tick = 1'b1;
    clk_step(1);
    clk_step(1);
    clk_step(1);
    check("mid_in_run", 32'(seq_run), 32'(1));
    do_reset();
    run_frame(1'b0, 1'b0);
    check("post_rst_seq_frame", 32'(seq_frame), 32'(0));
    check("post_rst_wr_frame",  32'(wr_frame),  32'(1));

    // Random runs with stray ticks, clears and write traffic.
    for (int i = 0; i < 25; i++) run_frame(1'($urandom_range(0, 1)), 1'b1);

    repeat (3) clk_step(0);
    check("wr_queue_empty",  32'(exp_wr.size()),  32'(0));
    check("run_queue_empty", 32'(exp_run.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
